// File: rtl/controller.sv
// controller -- top-level sequencer for an automatic slicing machine.
//
// Takes one ultrasonic measurement as the reference position, then alternates
// move and measure steps. A cut is requested each time the object has advanced
// by at least THICKNESS distance units since the last reference. The job ends
// (finish) after slice_num slices, which takes slice_num - 1 cuts.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH despite the legacy name
//   start       level; starts a job when the sequencer is idle or done
//   pause       freezes state and counters while high, forces move low
//   slice_num   slices for the job, captured at job start
//   valid       one-cycle sensor pulse, distance valid in the same cycle
//   distance    measured distance (unsigned)
//   triggerSuc  sensor acknowledge of trigger
//   trigger     measurement request, held until triggerSuc
//   move        advance request to the move controller
//   cut_end     one-cycle pulse from the cut controller when a cut is done
//   cut         cut request, held until cut_end
//   finish      high while the job is done
module controller #(
  parameter logic [31:0] THICKNESS   = 32'd200,
  parameter int          MOVE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [4:0]  slice_num,
  input  logic        valid,
  input  logic [31:0] distance,
  input  logic        triggerSuc,
  output logic        trigger,
  output logic        move,
  input  logic        cut_end,
  output logic        cut,
  output logic        finish
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_VAL,
    S_EVAL,
    S_MOVE,
    S_CUT,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [4:0]     target_q;
  logic [4:0]     cut_cnt_q;
  logic           first_q;
  logic [31:0]    ref_dist_q;
  logic [31:0]    cur_dist_q;
  logic [MCW-1:0] move_cnt_q;
  logic           trigger_q;
  logic           move_q;
  logic           cut_q;
  logic           finish_q;

  // Cut bookkeeping is done in 6 bits so that cut_cnt + 1 and target - 1
  // cannot wrap in the comparison.
  logic [5:0] cuts_done_d;
  logic [5:0] cuts_needed_d;
  logic       last_cut_d;
  logic [4:0] cut_cnt_d;
  logic       advanced_d;

  assign cuts_done_d   = {1'b0, cut_cnt_q} + 6'd1;
  assign cuts_needed_d = {1'b0, target_q} - 6'd1;
  assign last_cut_d    = (cuts_done_d >= cuts_needed_d);
  assign cut_cnt_d     = (cut_cnt_q == 5'd31) ? cut_cnt_q : cut_cnt_q + 5'd1;

  // A receding object (cur > ref) counts as zero advance, so the subtraction
  // is only meaningful when ref >= cur.
  assign advanced_d = (ref_dist_q >= cur_dist_q) &&
                      ((ref_dist_q - cur_dist_q) >= THICKNESS);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      cut_cnt_q  <= '0;
      first_q    <= 1'b1;
      ref_dist_q <= '0;
      cur_dist_q <= '0;
      move_cnt_q <= '0;
      trigger_q  <= 1'b0;
      move_q     <= 1'b0;
      cut_q      <= 1'b0;
      finish_q   <= 1'b0;
    end else if (!pause) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            target_q  <= slice_num;
            cut_cnt_q <= '0;
            first_q   <= 1'b1;
            finish_q  <= 1'b0;
            trigger_q <= 1'b1;
            state_q   <= S_TRIG;
          end
        end

        S_TRIG: begin
          if (triggerSuc) begin
            trigger_q <= 1'b0;
            state_q   <= S_WAIT_VAL;
          end
        end

        S_WAIT_VAL: begin
          if (valid) begin
            cur_dist_q <= distance;
            state_q    <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (first_q) begin
            ref_dist_q <= cur_dist_q;
            first_q    <= 1'b0;
            // One slice (or none) needs no cut at all.
            if (target_q <= 5'd1) begin
              finish_q <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              move_q     <= 1'b1;
              move_cnt_q <= '0;
              state_q    <= S_MOVE;
            end
          end else if (advanced_d) begin
            cut_q   <= 1'b1;
            state_q <= S_CUT;
          end else begin
            move_q     <= 1'b1;
            move_cnt_q <= '0;
            state_q    <= S_MOVE;
          end
        end

        S_MOVE: begin
          if (move_cnt_q == MOVE_LAST) begin
            move_q    <= 1'b0;
            trigger_q <= 1'b1;
            state_q   <= S_TRIG;
          end else begin
            move_cnt_q <= move_cnt_q + 1'b1;
          end
        end

        S_CUT: begin
          if (cut_end) begin
            cut_q      <= 1'b0;
            ref_dist_q <= cur_dist_q;
            cut_cnt_q  <= cut_cnt_d;
            if (last_cut_d) begin
              finish_q <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              move_q     <= 1'b1;
              move_cnt_q <= '0;
              state_q    <= S_MOVE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trigger = trigger_q;
  // Pause must stop the motor immediately, not one cycle later.
  assign move    = move_q & ~pause;
  assign cut     = cut_q;
  assign finish  = finish_q;

endmodule

// File: tb/tb_controller.sv
// tb_controller -- randomized, scoreboard-checked bench for controller.
//
// A job planner computes, from the slicing rules, the distance sequence the
// sensor will report and the ordered list of events the controller must
// produce (M = move pulse, C = cut request, D = finish). Sensor and cut
// controller emulators answer the DUT handshakes; a monitor pops the event
// queue on each rising move/cut/finish and compares.
module tb_controller;

  localparam int THICK = 200;
  localparam int MOVE_N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [4:0]  slice_num = '0;
  logic        valid = 1'b0;
  logic [31:0] distance = '0;
  logic        triggerSuc = 1'b0;
  logic        trigger;
  logic        move;
  logic        cut_end = 1'b0;
  logic        cut;
  logic        finish;

  int n_vec = 0;
  int n_err = 0;
  int job_cnt = 0;
  bit no_cut_end = 1'b0;

  logic [31:0] dist_q[$];
  byte         exp_q[$];
  int          dir_q[$];

  controller #(.THICKNESS(32'd200), .MOVE_CYCLES(MOVE_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .slice_num(slice_num), .valid(valid), .distance(distance),
    .triggerSuc(triggerSuc), .trigger(trigger), .move(move),
    .cut_end(cut_end), .cut(cut), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic ev(input byte got);
    byte e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got %c, expected none (t=%0t)", got, $time);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        n_err++;
        $display("FAIL event: got %c, expected %c (t=%0t)", got, e, $time);
      end
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] r);
    case ($urandom_range(4, 0))
      0:       return r + $urandom_range(300, 1);
      1:       return r - $urandom_range(150, 0);
      2:       return r - 32'(THICK - 1);
      3:       return r - 32'(THICK);
      default: return r - $urandom_range(500, 201);
    endcase
  endfunction

  // Walk the job one measurement at a time using the slicing rules.
  task automatic plan_job(input int sn);
    logic [31:0] refd, d;
    int cuts;
    bit first, done;
    first = 1; done = 0; cuts = 0; refd = 0;
    while (!done) begin
      if (dir_q.size() > 0) d = 32'(dir_q.pop_front());
      else if (first) d = $urandom_range(5000, 3000);
      else d = pick(refd);
      dist_q.push_back(d);
      if (first) begin
        first = 0;
        refd = d;
        if (sn <= 1) begin exp_q.push_back("D"); done = 1; end
        else exp_q.push_back("M");
      end else if (d <= refd && (refd - d) >= THICK) begin
        cuts++;
        refd = d;
        exp_q.push_back("C");
        if (cuts >= sn - 1) begin exp_q.push_back("D"); done = 1; end
        else exp_q.push_back("M");
      end else begin
        exp_q.push_back("M");
      end
    end
  endtask

  // Sensor emulator: acknowledges trigger, then returns the next distance.
  // A stray valid follows each real one and must be ignored.
  initial begin : sensor
    int dly;
    int n_trig;
    logic [31:0] d;
    n_trig = 0;
    forever begin
      @(negedge clk);
      if (!rst_n && trigger) begin
        dly = (n_trig == 0) ? 6 : int'($urandom_range(7, 2));
        n_trig++;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          chk("trig_hold", trigger, 1);
        end
        triggerSuc = 1'b1;
        @(negedge clk);
        triggerSuc = 1'b0;
        chk("trig_fall", trigger, 0);
        if (dist_q.size() == 0) begin
          chk("extra_trigger", 1, 0);
          d = 32'd0;
        end else begin
          d = dist_q.pop_front();
        end
        repeat (10) @(negedge clk);
        valid = 1'b1;
        distance = d;
        @(negedge clk);
        valid = 1'b0;
        distance = $urandom;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
      end
    end
  end

  // Cut controller emulator: holds off cut_end for a while, then pulses it.
  initial begin : cutter
    int dly;
    int n_cut;
    n_cut = 0;
    forever begin
      @(negedge clk);
      if (!rst_n && cut && !no_cut_end) begin
        dly = (n_cut == 0) ? 5 : int'($urandom_range(6, 1));
        n_cut++;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          chk("cut_hold", cut, 1);
        end
        cut_end = 1'b1;
        @(negedge clk);
        cut_end = 1'b0;
        chk("cut_fall", cut, 0);
        @(negedge clk);
        cut_end = 1'b1;
        @(negedge clk);
        cut_end = 1'b0;
      end
    end
  end

  // Monitor: one event per rising move pulse (counted in MOVE_N high cycles so
  // a pause gap does not create a new event), cut rise and finish rise.
  initial begin : monitor
    bit cut_p, fin_p, trig_p;
    int mcnt;
    cut_p = 0; fin_p = 0; trig_p = 0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mcnt = 0; cut_p = 0; fin_p = 0; trig_p = 0;
      end else begin
        if (move) begin
          if (mcnt == 0) ev("M");
          mcnt++;
          if (mcnt == MOVE_N) mcnt = 0;
        end
        if (cut && !cut_p) ev("C");
        if (finish && !fin_p) ev("D");
        if (trigger && !trig_p) chk("move_len", mcnt, 0);
        cut_p = cut; fin_p = finish; trig_p = trigger;
      end
    end
  end

  // mode 0: normal job with a mid-job start; 1: pause during move;
  // 2: reset while cut is high.
  task automatic run_job(input int sn, input int mode);
    int t;
    plan_job(sn);
    job_cnt++;
    no_cut_end = (mode == 2);
    @(negedge clk);
    slice_num = 5'(sn);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    slice_num = 5'($urandom);
    if (mode == 0) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (mode == 1) begin
      t = 0;
      while (!move && t < 500) begin @(negedge clk); t++; end
      chk("pause_reach_move", move, 1);
      @(posedge clk);
      #1 pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("pause_move", move, 0);
        chk("pause_trig", trigger, 0);
      end
      @(posedge clk);
      #1 pause = 1'b0;
    end
    if (mode == 2) begin
      t = 0;
      while (!cut && t < 500) begin @(negedge clk); t++; end
      chk("reset_reach_cut", cut, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("async_rst_trigger", trigger, 0);
      chk("async_rst_move", move, 0);
      chk("async_rst_cut", cut, 0);
      chk("async_rst_finish", finish, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      dist_q.delete();
      exp_q.delete();
      no_cut_end = 1'b0;
      $display("job %0d slice_num=%0d mode=%0d aborted by reset", job_cnt, sn, mode);
      return;
    end
    t = 0;
    while (!finish && t < 5000) begin @(negedge clk); t++; end
    chk("finish_reached", finish, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("done_no_trigger", trigger, 0);
    end
    chk("done_finish_held", finish, 1);
    chk("leftover_events", exp_q.size(), 0);
    chk("leftover_distances", dist_q.size(), 0);
    $display("job %0d slice_num=%0d mode=%0d complete after %0d cycles", job_cnt, sn, mode, t);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    chk("reset_trigger", trigger, 0);
    chk("reset_move", move, 0);
    chk("reset_cut", cut, 0);
    chk("reset_finish", finish, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    dir_q = '{900, 800, 600, 450, 280};
    run_job(3, 0);
    dir_q = '{500};
    run_job(1, 0);
    dir_q = '{900, 950, 710, 700};
    run_job(2, 0);
    dir_q.delete();
    run_job(4, 1);
    dir_q = '{900, 800, 600};
    run_job(3, 2);
    dir_q = '{900, 800, 600, 450, 280};
    run_job(3, 0);
    dir_q = '{700};
    run_job(0, 0);
    dir_q.delete();
    for (int j = 0; j < 8; j++) run_job(int'($urandom_range(6, 2)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Top-level sequencer for an automatic slicing machine.
- Starts an ultrasonic distance measurement and records the first result as the reference position. It then alternates "move" and "measure" steps, and requests a cut each time the object has advanced by at least one slice thickness.
- Raises finish once slice_num slices have been produced.
- Sits between the ultrasonic sensor interface, the move controller and the cut controller.

Parameters:
- THICKNESS, 200: required advance per slice, in sensor distance units. The comparison is unsigned 32-bit.
- MOVE_CYCLES, 4: number of cycles the move output is held high per move step.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous reset, active-high. The port keeps the codebase name, but reset is asserted when the signal is 1.
- start  in  1  level. Sampled in IDLE or DONE; starts a new job.
- pause  in  1  while 1, the FSM holds its state and counters and move is forced to 0.
- slice_num  in  5  number of slices for the job, captured when the job starts.
- valid  in  1  one-cycle pulse from the sensor; distance is valid in the same cycle.
- distance  in  32  measured distance, unsigned.
- triggerSuc  in  1  sensor acknowledge that the trigger was accepted.
- trigger  out  1  measurement request, held until triggerSuc.
- move  out  1  advance request to the move controller.
- cut_end  in  1  one-cycle pulse from the cut controller when a cut is complete.
- cut  out  1  cut request, held until cut_end.
- finish  out  1  high while in DONE.

Behaviour:
- Reset: state = IDLE. trigger, move, cut and finish are 0. ref_dist = 0, cut_cnt = 0, first = 1.
- IDLE: when start = 1, latch slice_num into target, clear cut_cnt, set first = 1, and go to TRIG.
- TRIG: trigger = 1. When triggerSuc = 1, set trigger = 0 on the next cycle and go to WAIT_VAL.
- WAIT_VAL: wait for valid = 1, then latch distance into cur_dist and go to EVAL.
- EVAL, exactly one cycle:
  - If first = 1: ref_dist = cur_dist, first = 0.
  - If first = 0 and ref_dist ≥ cur_dist and (ref_dist − cur_dist) ≥ THICKNESS: go to CUT.
  - Otherwise (including cur_dist > ref_dist, which is treated as zero advance): go to MOVE.
  - If target ≤ 1 while first = 1, go directly to DONE after the reference capture; no cut is needed.
- MOVE: move = 1 for MOVE_CYCLES cycles, then go to TRIG.
- CUT: cut = 1 until cut_end = 1. On cut_end, in the same edge:
  - set cut = 0;
  - ref_dist = cur_dist;
  - cut_cnt = cut_cnt + 1.
  - If cut_cnt + 1 ≥ target − 1 (slice_num slices need slice_num − 1 cuts), go to DONE; otherwise go to MOVE.
- DONE: finish = 1. When start = 1, set finish = 0 and begin a new job as from IDLE.
- Outputs are registered; each rises one cycle after the state entry decision.
- Inputs are ignored outside the state that waits on them: triggerSuc outside TRIG, valid outside WAIT_VAL, and cut_end outside CUT.
- Pause freezes every state and counter. trigger and cut hold their level during pause. An input pulse that arrives while paused is ignored.
- start asserted mid-job is ignored.
- An asynchronous reset mid-job returns the block to IDLE immediately and clears all outputs.
- Counters are 5 bits wide; cut_cnt never exceeds 31.

Test Plan:
- Basic job with slice_num = 3 and distances 900, 800, 600, 450, 280, with one triggerSuc pulse 2 cycles after each trigger rise and valid 10 cycles later:
  - 900 becomes the reference; 800 produces move only.
  - 600 raises cut; cut_end clears it and the reference becomes 600.
  - 450 produces move; 280 raises a second cut.
  - After that cut_end, finish = 1 and no further trigger occurs.
- Handshake: trigger stays high for 5 cycles without triggerSuc; after triggerSuc it falls within 1 cycle. Likewise cut stays high until cut_end.
- slice_num = 1: after the first measurement, finish = 1 with no move and no cut.
- Pause is asserted during MOVE for 20 cycles: move = 0 and the state is held; after release, the remaining move cycles complete and then trigger rises.
- Receding object with distances 900 then 950: no cut, move is issued again, and the reference stays 900.
- Reset asserted while cut = 1: all outputs are 0 asynchronously; after release, a new start runs a complete job correctly.
